video_irq_ctrl: RTL

VIDEO_IRQ_CTRL -- requirements
Module: video_irq_ctrl

---
 rtl/video_irq_ctrl_pkg.sv | 18 +
 rtl/irq_edge_pending.sv | 41 ++++
 rtl/video_irq_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/video_irq_ctrl_pkg.sv
// Shared constants for the video interrupt controller: RST opcode base,
// FSM state encoding and interrupt source IDs.
package video_irq_ctrl_pkg;

  localparam logic [7:0] RST_OPCODE_BASE = 8'hC7;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ASSERT = 1'b1;

  localparam logic [0:0] SRC_MID = 1'b0;
  localparam logic [0:0] SRC_VBL = 1'b1;

  // RST n opcode: 11 nnn 111
  function automatic logic [7:0] rst_opcode(input logic [2:0] rst_num);
    return RST_OPCODE_BASE | {2'b00, rst_num, 3'b000};
  endfunction

endpackage

// File: rtl/irq_edge_pending.sv
// Per-source rising-edge detector with a sticky pending flag and an overrun
// pulse for edges that arrive while the flag is still owed to the CPU.
module irq_edge_pending (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clr,
  output logic pending,
  output logic overrun
);

  logic prev_q;
  logic pending_q, pending_d;
  logic edge_det;

  assign edge_det = level & ~prev_q;

  // A fresh edge wins over a coincident clear, so the new event is kept.
  always_comb begin
    pending_d = pending_q;
    if (edge_det) begin
      pending_d = 1'b1;
    end else if (clr) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= level;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign overrun = edge_det & pending_q & ~clr;

endmodule

// File: rtl/video_irq_ctrl.sv
// Video interrupt controller: turns mid-screen and vblank edges into 8080-style
// RST interrupt requests, with vblank priority and a saturating overrun count.
module video_irq_ctrl
  import video_irq_ctrl_pkg::*;
#(
  parameter int unsigned MID_RST = 1,
  parameter int unsigned VBL_RST = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mid_screen,
  input  logic       vblank,
  input  logic       int_enable,
  input  logic       int_ack,
  output logic       irq,
  output logic [7:0] int_opcode,
  output logic [7:0] overrun_count
);

  localparam logic [2:0] MidNum = MID_RST[2:0];
  localparam logic [2:0] VblNum = VBL_RST[2:0];

  logic [0:0] state_q, state_d;
  logic [0:0] src_q, src_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_mid, pend_vbl;
  logic       ovr_mid, ovr_vbl;
  logic       ack_fire;
  logic [1:0] ovr_inc;
  logic [8:0] cnt_sum;

  assign ack_fire = (state_q == ST_ASSERT) & int_ack;

  irq_edge_pending u_mid (
    .clk     (clk),
    .rst     (rst),
    .level   (mid_screen),
    .clr     (ack_fire & (src_q == SRC_MID)),
    .pending (pend_mid),
    .overrun (ovr_mid)
  );

  irq_edge_pending u_vbl (
    .clk     (clk),
    .rst     (rst),
    .level   (vblank),
    .clr     (ack_fire & (src_q == SRC_VBL)),
    .pending (pend_vbl),
    .overrun (ovr_vbl)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (int_enable && (pend_vbl || pend_mid)) begin
          state_d = ST_ASSERT;
          src_d   = pend_vbl ? SRC_VBL : SRC_MID;
        end
      end
      ST_ASSERT: begin
        // Losing INTE withdraws the request but leaves the flag pending.
        if (int_ack || !int_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovr_inc = {1'b0, ovr_mid} + {1'b0, ovr_vbl};
  assign cnt_sum = {1'b0, cnt_q} + {7'b0, ovr_inc};
  assign cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_MID;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign irq           = (state_q == ST_ASSERT);
  assign int_opcode    = irq ? ((src_q == SRC_VBL) ? rst_opcode(VblNum) : rst_opcode(MidNum))
                             : 8'h00;
  assign overrun_count = cnt_q;

endmodule
